pacman_actor: RTL and testbench



---
 rtl/pacman_actor.sv | 234 +++++++++++++++++++++++
 tb/tb_pacman_actor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_actor.sv
// Grid actor for the maze game: steps one tile per step period using a buffered
// turn request, checks each step against border limits and a shared map-RAM port.
module pacman_actor #(
  parameter int COORD_W       = 5,
  parameter int TILE_SHIFT    = 3,
  parameter int SCREEN_OFFSET = 20,
  parameter int SPR_SIZE      = 16,
  parameter int BORDER_X_MIN  = 1,
  parameter int BORDER_X_MAX  = 28,
  parameter int BORDER_Y_MIN  = 1,
  parameter int BORDER_Y_MAX  = 28,
  parameter int START_X       = 2,
  parameter int START_Y       = 2,
  parameter int START_DIR     = 3,
  parameter int STEP_TICKS    = 15,
  parameter int ANIM_FRAMES   = 2,
  localparam int AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic [9:0]         shpos,
  input  logic [9:0]         svpos,
  input  logic               req_valid,
  input  logic [1:0]         req_dir,
  output logic               map_req,
  output logic [COORD_W-1:0] map_x,
  output logic [COORD_W-1:0] map_y,
  input  logic               map_ack,
  input  logic               map_wall,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic [1:0]         dir,
  output logic               moving,
  output logic               step_done,
  output logic [AW-1:0]      anim_frame,
  output logic               spr_on,
  output logic [3:0]         spr_x,
  output logic [3:0]         spr_y
);

  localparam int TW = $clog2(STEP_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_FWD, S_DONE} state_t;

  function automatic logic [2*COORD_W-1:0] neighbour(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y,
                                                     input logic [1:0]         d);
    logic [COORD_W-1:0] nx;
    logic [COORD_W-1:0] ny;
    nx = x;
    ny = y;
    case (d)
      2'd0:    ny = y - COORD_W'(1);
      2'd1:    nx = x - COORD_W'(1);
      2'd2:    ny = y + COORD_W'(1);
      default: nx = x + COORD_W'(1);
    endcase
    return {nx, ny};
  endfunction

  function automatic logic in_border(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
    return (int'(x) > BORDER_X_MIN) && (int'(x) < BORDER_X_MAX) &&
           (int'(y) > BORDER_Y_MIN) && (int'(y) < BORDER_Y_MAX);
  endfunction

  function automatic logic [AW-1:0] next_frame(input logic [AW-1:0] f);
    return (f == AW'(ANIM_FRAMES - 1)) ? '0 : f + AW'(1);
  endfunction

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, mx_q, mx_d, my_q, my_d;
  logic [1:0]         dir_q, dir_d, want_q, want_d, turn_dir_q, turn_dir_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic               pend_q, pend_d, moving_q, moving_d;
  logic [AW-1:0]      frame_q, frame_d;
  logic               spr_on_q, spr_on_d;
  logic [3:0]         spr_x_q, spr_x_d, spr_y_q, spr_y_d;

  logic [COORD_W-1:0] fx, fy, tx, ty;
  logic               fwd_ok, turn_ok, wrap;
  logic [9:0]         sx, sy, dx, dy;

  assign {fx, fy} = neighbour(x_q, y_q, dir_q);
  assign {tx, ty} = neighbour(x_q, y_q, want_q);
  assign fwd_ok   = in_border(fx, fy);
  assign turn_ok  = (want_q != dir_q) && in_border(tx, ty);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    mx_d       = mx_q;
    my_d       = my_q;
    dir_d      = dir_q;
    want_d     = want_q;
    turn_dir_d = turn_dir_q;
    tick_d     = tick_q;
    pend_d     = pend_q;
    moving_d   = moving_q;
    frame_d    = frame_q;
    wrap       = 1'b0;

    if (ce) begin
      if (tick_q == TW'(STEP_TICKS - 1)) begin
        tick_d = '0;
        wrap   = 1'b1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    if (req_valid) want_d = req_dir;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (turn_ok) begin
            state_d    = S_TURN;
            mx_d       = tx;
            my_d       = ty;
            turn_dir_d = want_q;
          end else if (fwd_ok) begin
            state_d = S_FWD;
            mx_d    = fx;
            my_d    = fy;
          end else begin
            state_d  = S_DONE;
            moving_d = 1'b0;
          end
        end
      end
      S_TURN: begin
        if (map_ack) begin
          if (!map_wall) begin
            state_d  = S_DONE;
            dir_d    = turn_dir_q;
            x_d      = mx_q;
            y_d      = my_q;
            frame_d  = next_frame(frame_q);
            moving_d = 1'b1;
          end else if (fwd_ok) begin
            // Turn tile is a wall: fall back to carrying on straight.
            state_d = S_FWD;
            mx_d    = fx;
            my_d    = fy;
          end else begin
            state_d  = S_DONE;
            moving_d = 1'b0;
          end
        end
      end
      S_FWD: begin
        if (map_ack) begin
          state_d = S_DONE;
          if (!map_wall) begin
            x_d      = mx_q;
            y_d      = my_q;
            frame_d  = next_frame(frame_q);
            moving_d = 1'b1;
          end else begin
            moving_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh period tick outranks the clear from the step it overlaps.
    if (wrap) pend_d = 1'b1;
  end

  always_comb begin
    sx       = (10'(x_q) << TILE_SHIFT) - 10'(SCREEN_OFFSET);
    sy       = (10'(y_q) << TILE_SHIFT) - 10'(SCREEN_OFFSET);
    dx       = shpos - sx;
    dy       = svpos - sy;
    spr_on_d = (dx < 10'(SPR_SIZE)) && (dy < 10'(SPR_SIZE));
    spr_x_d  = spr_on_d ? dx[3:0] : 4'd0;
    spr_y_d  = spr_on_d ? dy[3:0] : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x_q        <= COORD_W'(START_X);
      y_q        <= COORD_W'(START_Y);
      dir_q      <= 2'(START_DIR);
      want_q     <= 2'(START_DIR);
      turn_dir_q <= 2'(START_DIR);
      mx_q       <= '0;
      my_q       <= '0;
      tick_q     <= '0;
      pend_q     <= 1'b0;
      moving_q   <= 1'b0;
      frame_q    <= '0;
      spr_on_q   <= 1'b0;
      spr_x_q    <= 4'd0;
      spr_y_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      want_q     <= want_d;
      turn_dir_q <= turn_dir_d;
      mx_q       <= mx_d;
      my_q       <= my_d;
      tick_q     <= tick_d;
      pend_q     <= pend_d;
      moving_q   <= moving_d;
      frame_q    <= frame_d;
      spr_on_q   <= spr_on_d;
      spr_x_q    <= spr_x_d;
      spr_y_q    <= spr_y_d;
    end
  end

  assign map_req    = (state_q == S_TURN) || (state_q == S_FWD);
  assign step_done  = (state_q == S_DONE);
  assign map_x      = mx_q;
  assign map_y      = my_q;
  assign xpos       = x_q;
  assign ypos       = y_q;
  assign dir        = dir_q;
  assign moving     = moving_q;
  assign anim_frame = frame_q;
  assign spr_on     = spr_on_q;
  assign spr_x      = spr_x_q;
  assign spr_y      = spr_y_q;

endmodule

// File: tb/tb_pacman_actor.sv
// Bench for pacman_actor: directed corner sequences, a render vector table and a
// randomized run, all checked against a per-step tile model and a pixel model.
module tb_pacman_actor;

  logic       clk = 1'b0;
  logic       reset, ce, req_valid, map_ack, map_wall;
  logic [9:0] shpos, svpos;
  logic [1:0] req_dir;
  logic       map_req, moving, step_done, spr_on;
  logic [4:0] map_x, map_y, xpos, ypos;
  logic [1:0] dir;
  logic [0:0] anim_frame;
  logic [3:0] spr_x, spr_y;

  pacman_actor dut (
    .clk(clk), .reset(reset), .ce(ce), .shpos(shpos), .svpos(svpos),
    .req_valid(req_valid), .req_dir(req_dir), .map_req(map_req),
    .map_x(map_x), .map_y(map_y), .map_ack(map_ack), .map_wall(map_wall),
    .xpos(xpos), .ypos(ypos), .dir(dir), .moving(moving), .step_done(step_done),
    .anim_frame(anim_frame), .spr_on(spr_on), .spr_x(spr_x), .spr_y(spr_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    int on;
    int sx;
    int sy;
  } rvec_t;

  int vectors = 0;
  int miscompares = 0;
  bit wall [32][32];
  int ack_delay = 0;
  int dly = 0;
  bit busy = 1'b0;
  bit rchk = 1'b0;
  int qx[$], qy[$], lqx[$], lqy[$];
  int mx, my, md, mw, mf;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit legal(input int x, input int y);
    return x > 1 && x < 28 && y > 1 && y < 28;
  endfunction

  function automatic int nbx(input int x, input int d);
    return (x + int'(d == 3) - int'(d == 1)) & 31;
  endfunction

  function automatic int nby(input int y, input int d);
    return (y + int'(d == 2) - int'(d == 0)) & 31;
  endfunction

  // Whole-step outcome: which tiles get queried and where the actor ends up.
  task automatic model_check();
    int tx, ty, fx, fy, ex, ey, ed;
    bit mv;
    int eqx[$], eqy[$];
    tx = nbx(mx, mw); ty = nby(my, mw);
    fx = nbx(mx, md); fy = nby(my, md);
    ex = mx; ey = my; ed = md; mv = 1'b0;
    if (mw != md && legal(tx, ty)) begin
      eqx.push_back(tx); eqy.push_back(ty);
      if (!wall[tx][ty]) begin ex = tx; ey = ty; ed = mw; mv = 1'b1; end
    end
    if (!mv && legal(fx, fy)) begin
      eqx.push_back(fx); eqy.push_back(fy);
      if (!wall[fx][fy]) begin ex = fx; ey = fy; mv = 1'b1; end
    end
    if (mv) mf = (mf + 1) % 2;
    chk("step_xpos", xpos, ex);
    chk("step_ypos", ypos, ey);
    chk("step_dir", dir, ed);
    chk("step_moving", moving, mv);
    chk("step_frame", anim_frame, mf);
    chk("step_nqueries", qx.size(), eqx.size());
    for (int i = 0; i < qx.size() && i < eqx.size(); i++) begin
      chk("query_x", qx[i], eqx[i]);
      chk("query_y", qy[i], eqy[i]);
    end
    mx = ex; my = ey; md = ed;
    lqx = qx; lqy = qy;
    qx.delete(); qy.delete();
  endtask

  // One clock: map responder, request-hold check, render check, step check.
  task automatic cycle();
    int ph, pv, px, py, sx, sy, dx, dy, eon;
    ph = shpos; pv = svpos; px = xpos; py = ypos;
    @(posedge clk);
    #1;
    if (map_ack) begin
      map_ack = 1'b0; map_wall = 1'b0; busy = 1'b0;
    end
    if (busy) begin
      chk("map_req_held", map_req, 1);
      chk("map_x_held", map_x, qx[$]);
      chk("map_y_held", map_y, qy[$]);
    end
    if (map_req && !busy) begin
      busy = 1'b1;
      qx.push_back(map_x); qy.push_back(map_y);
      dly = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
    end
    if (busy) begin
      if (dly == 0) begin
        map_ack = 1'b1; map_wall = wall[map_x][map_y];
      end else dly--;
    end
    if (rchk) begin
      sx = (px * 8 - 20) & 1023; sy = (py * 8 - 20) & 1023;
      dx = (ph - sx) & 1023;     dy = (pv - sy) & 1023;
      eon = int'(dx < 16 && dy < 16);
      chk("spr_on", spr_on, eon);
      chk("spr_x", spr_x, eon ? (dx & 15) : 0);
      chk("spr_y", spr_y, eon ? (dy & 15) : 0);
    end
    if (step_done) model_check();
  endtask

  task automatic do_reset();
    reset = 1'b1; ce = 1'b0; req_valid = 1'b0; map_ack = 1'b0; map_wall = 1'b0;
    busy = 1'b0; rchk = 1'b0;
    qx.delete(); qy.delete();
    cycle(); cycle();
    reset = 1'b0;
    mx = 2; my = 2; md = 3; mw = 3; mf = 0;
    rchk = 1'b1;
  endtask

  task automatic do_step();
    int n = 0;
    do begin cycle(); n++; end while (!step_done && n < 300);
    if (!step_done) chk("step_timeout", 0, 1);
  endtask

  task automatic set_req(input int d);
    req_valid = 1'b1; req_dir = 2'(d); mw = d;
    cycle();
    req_valid = 1'b0;
  endtask

  rvec_t tbl[8];

  initial begin
    int n, t;
    tbl[0] = '{20, 20, 1, 0, 0};
    tbl[1] = '{35, 20, 1, 15, 0};
    tbl[2] = '{36, 20, 0, 0, 0};
    tbl[3] = '{20, 35, 1, 0, 15};
    tbl[4] = '{20, 36, 0, 0, 0};
    tbl[5] = '{19, 20, 0, 0, 0};
    tbl[6] = '{27, 30, 1, 7, 10};
    tbl[7] = '{0, 0, 0, 0, 0};
    shpos = 10'd0; svpos = 10'd0; req_dir = 2'd0;
    foreach (wall[i, j]) wall[i][j] = 1'b0;

    do_reset();
    chk("rst_xpos", xpos, 2);
    chk("rst_ypos", ypos, 2);
    chk("rst_dir", dir, 3);
    chk("rst_frame", anim_frame, 0);
    chk("rst_map_req", map_req, 0);
    chk("rst_map_x", map_x, 0);
    chk("rst_moving", moving, 0);
    chk("rst_step_done", step_done, 0);
    chk("rst_spr_on", spr_on, 0);

    // First step: query issued on the 16th ce cycle, zero-wait ack.
    ce = 1'b1;
    repeat (15) cycle();
    chk("early_map_req", map_req, 0);
    cycle();
    chk("first_map_req", map_req, 1);
    chk("first_map_x", map_x, 3);
    chk("first_map_y", map_y, 2);
    cycle();
    chk("first_step_done", step_done, 1);
    chk("first_xpos", xpos, 3);
    chk("first_moving", moving, 1);
    chk("first_frame", anim_frame, 1);
    cycle();
    chk("step_done_pulse", step_done, 0);

    // Wall straight ahead.
    wall[4][2] = 1'b1;
    do_step();
    chk("wall_xpos", xpos, 3);
    chk("wall_moving", moving, 0);
    chk("wall_frame", anim_frame, 1);
    wall[4][2] = 1'b0;

    set_req(2);
    repeat (3) do_step();
    chk("down_ypos", ypos, 5);
    chk("down_dir", dir, 2);
    set_req(3);
    repeat (2) do_step();
    chk("at55_x", xpos, 5);
    chk("at55_y", ypos, 5);

    ce = 1'b0;
    foreach (tbl[i]) begin
      shpos = 10'(tbl[i].h); svpos = 10'(tbl[i].v);
      cycle();
      chk("tbl_spr_on", spr_on, tbl[i].on);
      chk("tbl_spr_x", spr_x, tbl[i].sx);
      chk("tbl_spr_y", spr_y, tbl[i].sy);
    end
    ce = 1'b1;

    // Buffered turn: blocked turn falls back to forward, next step turns.
    set_req(2);
    wall[5][6] = 1'b1;
    do_step();
    chk("bt_nq", lqx.size(), 2);
    chk("bt_fwd_qx", (lqx.size() > 1) ? lqx[1] : -1, 6);
    chk("bt_fwd_qy", (lqy.size() > 1) ? lqy[1] : -1, 5);
    chk("bt_xpos", xpos, 6);
    chk("bt_dir", dir, 3);
    wall[5][6] = 1'b0;
    do_step();
    chk("bt2_dir", dir, 2);
    chk("bt2_ypos", ypos, 6);

    // Border on the right, then on the left.
    set_req(3);
    for (int i = 0; i < 30 && xpos != 27; i++) do_step();
    do_step();
    chk("brd_r_x", xpos, 27);
    chk("brd_r_moving", moving, 0);
    chk("brd_r_nq", lqx.size(), 0);
    set_req(1);
    for (int i = 0; i < 30 && xpos != 2; i++) do_step();
    do_step();
    chk("brd_l_x", xpos, 2);
    chk("brd_l_moving", moving, 0);
    chk("brd_l_nq", lqx.size(), 0);

    // Slow map: two period ticks land while waiting; only one step is queued.
    set_req(2);
    ack_delay = 32;
    do_step();
    ack_delay = 0;
    cycle();
    chk("slow_idle_req", map_req, 0);
    cycle();
    chk("slow_backlog_req", map_req, 1);
    do_step();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("slow_no_queue", map_req, 0);
    end

    // Reset while a forward query is outstanding.
    ack_delay = 1000;
    n = 0;
    while (!map_req && n < 100) begin cycle(); n++; end
    chk("mid_req_seen", map_req, 1);
    rchk = 1'b0; reset = 1'b1; busy = 1'b0; map_ack = 1'b0;
    cycle();
    chk("rst_mid_map_req", map_req, 0);
    chk("rst_mid_xpos", xpos, 2);
    chk("rst_mid_ypos", ypos, 2);
    do_reset();

    // Randomized run against the step and pixel models.
    ack_delay = -1;
    foreach (wall[i, j]) wall[i][j] = ($urandom % 4 == 0);
    for (int i = 0; i < 4000; i++) begin
      ce = ($urandom % 4 != 0);
      if ($urandom % 2) begin
        t = xpos * 8 - 20 + int'($urandom_range(0, 19)) - 2;
        shpos = 10'(t);
        t = ypos * 8 - 20 + int'($urandom_range(0, 19)) - 2;
        svpos = 10'(t);
      end else begin
        shpos = 10'($urandom); svpos = 10'($urandom);
      end
      cycle();
      req_valid = 1'b0;
      if (step_done && ($urandom % 2 == 1)) begin
        req_dir = 2'($urandom); req_valid = 1'b1; mw = int'(req_dir);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
